// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Constants and types shared by the instruction-memory loader
//                and the fetch-side instruction store: memory geometry, loader
//                state encodings and byte-lane ordering of packed words.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Geometry of the instruction memory (word addressed, 32-bit words).
  localparam int IMEM_ADDR_W = 5;
  localparam int IMEM_DEPTH  = 32;

  // Byte-lane ordering: 1 = little-endian (first byte lands in bits [7:0]).
  localparam bit BYTE_LANE_LE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  // Bit offset of the lane that stream byte number idx occupies in a word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] idx);
    logic [1:0] lane;
    lane = BYTE_LANE_LE ? idx : ~idx;
    return {lane, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_word_packer
//  Description : Packs an accepted byte stream into 32-bit words using the
//                package lane ordering.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clear         - restart packing at byte 0 with an empty word
//                byte_in       - stream byte
//                byte_accept   - byte_in is taken this cycle
//                word          - assembly register
//                word_valid    - pulse with the 4th accepted byte; word holds
//                                the complete value from the next cycle on
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (byte_accept) begin
      word_d[lane_lsb(idx_q) +: 8] = byte_in;
      idx_d                        = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word       = word_q;
  assign word_valid = byte_accept && !clear && (idx_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a program into the instruction memory from a byte
//                stream, holding the core in reset while loading and
//                reporting completion and an XOR checksum of written words.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                start, word_count      - load request and its length (1..DEPTH)
//                abort                  - cancel an in-progress load
//                byte_in/valid/ready    - byte stream handshake
//                mem_we/addr/wdata      - instruction-memory write port
//                core_hold, busy        - high while a load is in progress
//                done                   - pulse after the last word is written
//                err                    - sticky illegal-count flag
//                checksum               - XOR of words of current/last load
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              err_q, err_d;
  // Last written address/data, so the write port holds still between writes.
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [31:0]       last_wdata_q, last_wdata_d;

  logic        pack_clear;
  logic        pack_accept;
  logic [31:0] packed_word;
  logic        packed_valid;
  logic        count_legal;
  logic        last_word;

  assign count_legal = (word_count != '0) && (word_count <= DEPTH_CNT);
  assign last_word   = ({1'b0, addr_q} == (count_q - 1'b1));
  assign pack_accept = byte_valid && byte_ready;

  imem_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (pack_clear),
    .byte_in     (byte_in),
    .byte_accept (pack_accept),
    .word        (packed_word),
    .word_valid  (packed_valid)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    checksum_d   = checksum_q;
    err_d        = err_q;
    last_addr_d  = last_addr_q;
    last_wdata_d = last_wdata_q;
    pack_clear   = 1'b0;
    byte_ready   = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = last_addr_q;
    mem_wdata    = last_wdata_q;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_legal) begin
            count_d    = word_count;
            checksum_d = '0;
            addr_d     = '0;
            pack_clear = 1'b1;
            err_d      = 1'b0;
            state_d    = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        byte_ready = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (packed_valid) begin
          state_d = WRITE;
        end
      end

      // The write itself always completes, even when abort arrives with it.
      WRITE: begin
        mem_we       = 1'b1;
        mem_addr     = addr_q;
        mem_wdata    = packed_word;
        last_addr_d  = addr_q;
        last_wdata_d = packed_word;
        checksum_d   = checksum_q ^ packed_word;
        pack_clear   = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (last_word) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = LOAD;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      checksum_q   <= '0;
      err_q        <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      checksum_q   <= checksum_d;
      err_q        <= err_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign core_hold = busy;
  assign err       = err_q;
  assign checksum  = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              abort = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       checksum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observation log, filled on the falling edge.
  int          wr_n   = 0;
  int          acc_n  = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  int          wr_cyc  [64];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = {27'b0, mem_addr};
        wr_data[wr_n] = mem_wdata;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
    end
    if (byte_valid && byte_ready) acc_n++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send the four bytes of w (little-endian) and return once the last is taken.
  task automatic feed_word(input logic [31:0] w);
    logic got;
    for (int i = 0; i < 4; i++) begin
      byte_in    = w[8*i +: 8];
      byte_valid = 1'b1;
      got        = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        got = byte_ready;
        tick();
      end
      if (!got) chk("feed_timeout", {31'b0, got}, 32'd1);
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int base_done);
    for (int k = 0; k < 40 && done_n == base_done; k++) tick();
    chk("done_pulse_count", done_n - base_done, 32'd1);
  endtask

  int          bw, bd, ba, bad_a, bad_d;
  logic [31:0] exp_ck, w;
  int          pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_byte_ready", {31'b0, byte_ready}, 0);
    chk("rst_mem_we",     {31'b0, mem_we},     0);
    chk("rst_busy",       {31'b0, busy},       0);
    chk("rst_core_hold",  {31'b0, core_hold},  0);
    chk("rst_err",        {31'b0, err},        0);
    chk("rst_checksum",   checksum,            0);
    rst = 1'b0;
    tick();

    // Nominal two-word load with byte_valid held high
    bw = wr_n; bd = done_n;
    word_count = 6'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_core_hold_after_start", {31'b0, core_hold}, 1);
    chk("t1_busy_after_start",      {31'b0, busy},      1);
    feed_word(32'h0000_0013);
    feed_word(32'h0050_02B3);
    wait_done(bd);
    chk("t1_write_count", wr_n - bw, 2);
    chk("t1_addr0",  wr_addr[bw],     0);
    chk("t1_data0",  wr_data[bw],     32'h0000_0013);
    chk("t1_addr1",  wr_addr[bw+1],   1);
    chk("t1_data1",  wr_data[bw+1],   32'h0050_02B3);
    chk("t1_word_spacing", wr_cyc[bw+1] - wr_cyc[bw], 5);
    chk("t1_done_after_write", done_cyc - wr_cyc[bw+1], 1);
    chk("t1_checksum", checksum, 32'h0050_02A0);
    chk("t1_core_hold_after_done", {31'b0, core_hold}, 0);

    // Stalled stream, single word
    bw = wr_n; bd = done_n; ba = acc_n;
    word_count = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      byte_valid = pat[i][0];
      byte_in    = 8'(8'h10 + i);
      tick();
    end
    byte_valid = 1'b1; byte_in = 8'hFF;
    chk("t2_write_cycle_mem_we",     {31'b0, mem_we},     1);
    chk("t2_write_cycle_byte_ready", {31'b0, byte_ready}, 0);
    tick();
    byte_valid = 1'b0;
    wait_done(bd);
    chk("t2_bytes_accepted", acc_n - ba, 4);
    chk("t2_write_count",    wr_n - bw,  1);
    chk("t2_data",           wr_data[bw], 32'h1614_1310);
    chk("t2_checksum",       checksum,    32'h1614_1310);

    // Illegal counts, then a legal start clears err
    bw = wr_n;
    word_count = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_err_count0",  {31'b0, err},  1);
    chk("t3_busy_count0", {31'b0, busy}, 0);
    word_count = 6'd33; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t3_err_count33",  {31'b0, err},  1);
    chk("t3_busy_count33", {31'b0, busy}, 0);
    chk("t3_no_writes",    wr_n - bw,     0);
    bd = done_n;
    word_count = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_err_cleared", {31'b0, err},  0);
    chk("t3_busy_legal",  {31'b0, busy}, 1);
    feed_word(32'hA4A3_A2A1);
    wait_done(bd);

    // Full memory
    bw = wr_n; bd = done_n; exp_ck = '0;
    word_count = 6'd32; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w = 32'(i) * 32'h0101_0101;
      exp_ck = exp_ck ^ w;
      feed_word(w);
    end
    wait_done(bd);
    chk("t4_write_count", wr_n - bw, 32);
    bad_a = 0; bad_d = 0;
    for (int i = 0; i < 32; i++) begin
      if (wr_addr[bw+i] !== 32'(i)) bad_a++;
      if (wr_data[bw+i] !== 32'(i) * 32'h0101_0101) bad_d++;
    end
    chk("t4_addr_order_errs", bad_a, 0);
    chk("t4_data_errs",       bad_d, 0);
    chk("t4_last_addr",       wr_addr[bw+31], 31);
    chk("t4_checksum",        checksum, exp_ck);

    // Abort after two words of a four-word load
    bw = wr_n; bd = done_n;
    word_count = 6'd4; start = 1'b1;
    tick();
    start = 1'b0;
    feed_word(32'h4433_2211);
    feed_word(32'h8877_6655);
    tick();
    byte_valid = 1'b1; byte_in = 8'h99;
    tick();
    byte_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy_after_abort",      {31'b0, busy},      0);
    chk("t5_core_hold_after_abort", {31'b0, core_hold}, 0);
    chk("t5_checksum",              checksum, 32'hCC44_4444);
    repeat (3) tick();
    chk("t5_no_done",     done_n - bd, 0);
    chk("t5_write_count", wr_n - bw,   2);

    // Reset in the middle of the second word
    word_count = 6'd2; start = 1'b1;
    tick();
    start = 1'b0;
    feed_word(32'h0BAD_F00D);
    tick();
    byte_valid = 1'b1; byte_in = 8'h77;
    tick();
    byte_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_byte_ready", {31'b0, byte_ready}, 0);
    chk("t6_mem_we",     {31'b0, mem_we},     0);
    chk("t6_mem_addr",   {27'b0, mem_addr},   0);
    chk("t6_mem_wdata",  mem_wdata,           0);
    chk("t6_core_hold",  {31'b0, core_hold},  0);
    chk("t6_busy",       {31'b0, busy},       0);
    chk("t6_done",       {31'b0, done},       0);
    chk("t6_checksum",   checksum,            0);
    bw = wr_n; bd = done_n;
    word_count = 6'd1; start = 1'b1;
    tick();
    start = 1'b0;
    feed_word(32'hEFBE_ADDE);
    wait_done(bd);
    chk("t6_write_count", wr_n - bw,   1);
    chk("t6_addr",        wr_addr[bw], 0);
    chk("t6_data",        wr_data[bw], 32'hEFBE_ADDE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
